// File: rtl/div_sequencer_if.sv
// Divider request/response bundle between the EXE stage and div_sequencer.
// The master drives the instruction and flush; the slave returns stall, done pulse and result.
interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            exe_div_valid;
  logic [1:0]      exe_div_op;
  logic [XLEN-1:0] exe_opA;
  logic [XLEN-1:0] exe_opB;
  logic            abort;
  logic            div_running;
  logic            div_done;
  logic [XLEN-1:0] div_result;

  modport master (
    output exe_div_valid, exe_div_op, exe_opA, exe_opB, abort,
    input  div_running, div_done, div_result
  );

  modport slave (
    input  exe_div_valid, exe_div_op, exe_opA, exe_opB, abort,
    output div_running, div_done, div_result
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU: 33-cycle stall, div_done on cycle 33.
// Divide-by-zero and signed overflow finish in one stall cycle; abort kills the operation without a pulse.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          nrst,
  div_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [5:0]      cnt;
  logic            op_rem, neg_q, neg_r;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q, result_q;

  logic            accept, is_signed, div_zero, ovf, special, last_step;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [XLEN:0]   rem_shift, diff;
  logic [XLEN-1:0] quo_step, rem_step, quo_fix, rem_fix;

  assign accept    = (state == IDLE) && bus.exe_div_valid && !bus.abort;
  assign is_signed = !bus.exe_div_op[0];
  assign abs_a     = (is_signed && bus.exe_opA[XLEN-1]) ? -bus.exe_opA : bus.exe_opA;
  assign abs_b     = (is_signed && bus.exe_opB[XLEN-1]) ? -bus.exe_opB : bus.exe_opB;
  assign div_zero  = (bus.exe_opB == '0);
  assign ovf       = is_signed && (bus.exe_opA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.exe_opB == '1);
  assign special   = div_zero || ovf;
  // Overflow: quotient equals the dividend (most negative value) and remainder is zero.
  assign special_res = div_zero ? (bus.exe_div_op[1] ? bus.exe_opA : '1)
                                : (bus.exe_div_op[1] ? '0 : bus.exe_opA);

  // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign quo_step  = {quo_q[XLEN-2:0], !diff[XLEN]};
  assign rem_step  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_fix   = neg_q ? -quo_step : quo_step;
  assign rem_fix   = neg_r ? -rem_step : rem_step;
  assign last_step = (state == RUN) && !bus.abort && (cnt == '0);

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : RUN;
      RUN:     if (bus.abort) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.div_running = 1'b0;
    bus.div_done    = 1'b0;
    if (!nrst) begin
      bus.div_running = accept || ((state == RUN) && !bus.abort);
      bus.div_done    = (state == DONE) && !bus.abort;
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      cnt      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt    <= 6'(XLEN-1);
      op_rem <= bus.exe_div_op[1];
      neg_q  <= is_signed && (bus.exe_opA[XLEN-1] ^ bus.exe_opB[XLEN-1]);
      neg_r  <= is_signed && bus.exe_opA[XLEN-1];
      quo_q  <= abs_a;
      rem_q  <= '0;
      dvs_q  <= abs_b;
      if (special) result_q <= special_res;
    end else if ((state == RUN) && !bus.abort) begin
      cnt   <= cnt - 6'd1;
      quo_q <= quo_step;
      rem_q <= rem_step;
      if (last_step) result_q <= op_rem ? rem_fix : quo_fix;
    end
  end

  assign bus.div_result = result_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table of divides plus abort, reset and back-to-back sequences.
module tb_div_sequencer;
  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  div_sequencer_if #(.XLEN(32)) bus ();

  div_sequencer #(.XLEN(32)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          run;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one instruction and watches 45 cycles; valid is held while stalled and dropped after done/abort.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, output int run_cycles, output int done_at,
                        output int done_cnt, output logic [31:0] res);
    bit stop;
    run_cycles = 0;
    done_at    = -1;
    done_cnt   = 0;
    res        = 32'hDEAD_BEEF;
    stop       = 1'b0;
    @(negedge clk);
    bus.exe_div_valid = 1'b1;
    bus.exe_div_op    = op;
    bus.exe_opA       = a;
    bus.exe_opB       = b;
    bus.abort         = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c == abort_at) bus.abort = 1'b1;
      else if (c > 0 && !stop) begin
        bus.exe_opA = $urandom;
        bus.exe_opB = $urandom;
      end
      #1;
      if (bus.div_running) run_cycles++;
      if (bus.div_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          res     = bus.div_result;
        end
      end
      if (bus.div_done || c == abort_at) stop = 1'b1;
      @(negedge clk);
      if (stop) begin
        bus.exe_div_valid = 1'b0;
        bus.abort         = 1'b0;
      end
    end
  endtask

  int          rc, da, dc;
  logic [31:0] rs;

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b1;
    bus.exe_div_valid = 1'b1;
    bus.exe_div_op    = 2'b01;
    bus.exe_opA       = 32'd100;
    bus.exe_opB       = 32'd7;
    bus.abort         = 1'b0;

    tbl[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        33, 33};
    tbl[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         33, 33};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 33};
    tbl[3]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 33};
    tbl[4]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1};
    tbl[5]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1,  1};
    tbl[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1};
    tbl[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1};
    tbl[8]  = '{2'b01, 32'd0,         32'd5,         32'd0,         33, 33};
    tbl[9]  = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 33};
    tbl[10] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33};
    tbl[11] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 33};
    tbl[12] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 33};
    tbl[13] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 33};
    tbl[14] = '{2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3,         33, 33};
    tbl[15] = '{2'b10, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 33, 33};

    // Reset state, with a valid request present that must not stall the pipe.
    #12;
    check("rst_running", {31'd0, bus.div_running}, 32'd0);
    check("rst_done",    {31'd0, bus.div_done},    32'd0);
    check("rst_result",  bus.div_result,           32'd0);
    @(negedge clk);
    bus.exe_div_valid = 1'b0;
    nrst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, rc, da, dc, rs);
      check($sformatf("v%0d_result", i),  rs,         tbl[i].exp);
      check($sformatf("v%0d_done_at", i), 32'(da),    32'(tbl[i].lat));
      check($sformatf("v%0d_running", i), 32'(rc),    32'(tbl[i].run));
      check($sformatf("v%0d_pulses", i),  32'(dc),    32'd1);
    end

    // Abort in the tenth RUN cycle: no pulse, previous result held.
    run_op(2'b01, 32'd100, 32'd7, 10, rc, da, dc, rs);
    check("abort_pulses",  32'(dc), 32'd0);
    check("abort_running", 32'(rc), 32'd10);
    check("abort_result",  bus.div_result, tbl[NV-1].exp);
    run_op(2'b01, 32'd9, 32'd3, -1, rc, da, dc, rs);
    check("post_abort_result",  rs,      32'd3);
    check("post_abort_done_at", 32'(da), 32'd33);
    check("post_abort_pulses",  32'(dc), 32'd1);

    // Asynchronous reset in mid-RUN.
    @(negedge clk);
    bus.exe_div_valid = 1'b1;
    bus.exe_div_op    = 2'b01;
    bus.exe_opA       = 32'd100;
    bus.exe_opB       = 32'd7;
    repeat (6) @(negedge clk);
    #2 nrst = 1'b1;
    #1;
    check("midrst_running", {31'd0, bus.div_running}, 32'd0);
    check("midrst_done",    {31'd0, bus.div_done},    32'd0);
    check("midrst_result",  bus.div_result,           32'd0);
    @(negedge clk);
    bus.exe_div_valid = 1'b0;
    nrst = 1'b0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.div_done || bus.div_running) dc++;
      @(negedge clk);
    end
    check("midrst_quiet", 32'(dc), 32'd0);

    // Back-to-back: DIV 20/4 then REM 20/6 issued the cycle after the first done.
    begin
      int          n_done, runs, d1_at, d2_at;
      logic [31:0] r1, r2;
      bit          seen;
      n_done = 0; runs = 0; d1_at = -1; d2_at = -1; r1 = '0; r2 = '0;
      bus.exe_div_valid = 1'b1;
      bus.exe_div_op    = 2'b00;
      bus.exe_opA       = 32'd20;
      bus.exe_opB       = 32'd4;
      for (int c = 0; c < 80; c++) begin
        #1;
        seen = bus.div_done;
        if (bus.div_running) runs++;
        if (seen) begin
          n_done++;
          if (n_done == 1) begin d1_at = c; r1 = bus.div_result; end
          else if (n_done == 2) begin d2_at = c; r2 = bus.div_result; end
        end
        @(negedge clk);
        if (seen && n_done == 1) begin
          bus.exe_div_op = 2'b10;
          bus.exe_opB    = 32'd6;
        end else if (seen) begin
          bus.exe_div_valid = 1'b0;
        end
      end
      check("b2b_r1",      r1,          32'd5);
      check("b2b_d1_at",   32'(d1_at),  32'd33);
      check("b2b_r2",      r2,          32'd2);
      check("b2b_d2_at",   32'(d2_at),  32'd67);
      check("b2b_pulses",  32'(n_done), 32'd2);
      check("b2b_running", 32'(runs),   32'd66);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
